mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_load_align.sv | 31 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and types for the memory arbiter
//
// Contents:
//   ADDR_W_DEFAULT   default word-address width of the shared memory
//   BE_*             legal byte-enable patterns
//   state_t          owner of the pending response (IDLE / RESP_IM / RESP_DM)
//   be_legal()       true for the seven byte-enable patterns the memory accepts
package mem_arbiter_pkg;

    localparam int ADDR_W_DEFAULT = 12;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESP_IM = 2'd1,
        ST_RESP_DM = 2'd2
    } state_t;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: be_legal = 1'b1;
            default:                                        be_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_load_align.sv
// rtl/mem_arbiter_load_align.sv - load lane extraction and zero/sign extension
//
// Ports:
//   rdata     in  32  raw memory word
//   be        in  4   byte enables registered at grant
//   sign_ext  in  1   sign-extend from the top enabled bit
//   data      out 32  enabled lanes shifted down to bit 0, extended
module load_align
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  be,
    input  logic        sign_ext,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (be)
            BE_B0: data = {{24{sign_ext & rdata[7]}},  rdata[7:0]};
            BE_B1: data = {{24{sign_ext & rdata[15]}}, rdata[15:8]};
            BE_B2: data = {{24{sign_ext & rdata[23]}}, rdata[23:16]};
            BE_B3: data = {{24{sign_ext & rdata[31]}}, rdata[31:24]};
            BE_H0: data = {{16{sign_ext & rdata[15]}}, rdata[15:0]};
            BE_H1: data = {{16{sign_ext & rdata[31]}}, rdata[31:16]};
            BE_W:  data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master (fetch/data) arbiter onto one single-port memory
//
// Ports:
//   clk, resetb                          clock, async active-low reset
//   im_req/im_addr/im_ready              fetch request and acceptance
//   im_valid/im_data                     fetch response, one cycle after acceptance
//   dm_req/dm_we/dm_addr/dm_be/dm_signed/dm_di/dm_ready   data request and acceptance
//   dm_valid/dm_do/dm_err                data response, one cycle after acceptance
//   mem_en/mem_we/mem_addr/mem_wdata     memory command (combinational from the grant)
//   mem_rdata                            memory read data, one cycle after mem_en
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              im_req,
    input  logic [31:0]       im_addr,
    output logic              im_ready,
    output logic              im_valid,
    output logic [31:0]       im_data,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [3:0]        dm_be,
    input  logic              dm_signed,
    input  logic [31:0]       dm_di,
    output logic              dm_ready,
    output logic              dm_valid,
    output logic [31:0]       dm_do,
    output logic              dm_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [3:0]       be_q;
    logic             sgn_q;
    logic             err_q;
    logic             store_q;
    logic             im_oor_q;

    logic        im_win;
    logic        dm_win;
    logic        dm_bad;
    logic        im_oor;
    logic        dm_go;
    logic [31:0] load_data;

    // Byte-offset bits never reach the word-addressed memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{im_addr[1:0], dm_addr[1:0]};

    // Anything above the top word-address bit lies outside the memory.
    assign im_oor = |im_addr[31:ADDR_W+2];
    assign dm_bad = !be_legal(dm_be) || (|dm_addr[31:ADDR_W+2]);

    // Data wins unless fetch has already lost STARVE_MAX times in a row.
    // Gating with resetb keeps every combinational output quiet during reset.
    assign im_win = resetb && im_req && (!dm_req || starve_cnt == CNT_MAX);
    assign dm_win = resetb && dm_req && !im_win;
    assign dm_go  = dm_win && !dm_bad;

    assign im_ready = im_win;
    assign dm_ready = dm_win;

    // Illegal or out-of-range requests are accepted but never touch memory.
    assign mem_en = (im_win && !im_oor) || dm_go;
    assign mem_we = (dm_go && dm_we) ? dm_be : 4'b0000;

    always_comb begin
        mem_addr = '0;
        if (dm_win)
            mem_addr = dm_addr[ADDR_W+1:2];
        else if (im_win)
            mem_addr = im_addr[ADDR_W+1:2];
    end

    // Store data is replicated so the lane selected by the strobes carries it.
    always_comb begin
        mem_wdata = '0;
        if (dm_go && dm_we) begin
            case (dm_be)
                BE_B0, BE_B1, BE_B2, BE_B3: mem_wdata = {4{dm_di[7:0]}};
                BE_H0, BE_H1:               mem_wdata = {2{dm_di[15:0]}};
                default:                    mem_wdata = dm_di;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            be_q       <= 4'b0000;
            sgn_q      <= 1'b0;
            err_q      <= 1'b0;
            store_q    <= 1'b0;
            im_oor_q   <= 1'b0;
        end else begin
            // Response owner follows this cycle's grant and nothing else.
            if (dm_win)
                state <= ST_RESP_DM;
            else if (im_win)
                state <= ST_RESP_IM;
            else
                state <= ST_IDLE;

            if (!im_req || im_win)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;

            // Capture how to shape the response; later request changes must not affect it.
            if (dm_win) begin
                be_q    <= dm_be;
                sgn_q   <= dm_signed;
                err_q   <= dm_bad;
                store_q <= dm_we;
            end
            if (im_win)
                im_oor_q <= im_oor;
        end
    end

    load_align u_load_align (
        .rdata    (mem_rdata),
        .be       (be_q),
        .sign_ext (sgn_q),
        .data     (load_data)
    );

    // Responses are decoded from the registered owner, so only one valid can be high.
    assign im_valid = (state == ST_RESP_IM);
    assign im_data  = (im_valid && !im_oor_q) ? mem_rdata : 32'h0;
    assign dm_valid = (state == ST_RESP_DM);
    assign dm_err   = dm_valid && err_q;
    assign dm_do    = (dm_valid && !err_q && !store_q) ? load_data : 32'h0;

endmodule
